div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle iterative divider attached to the EX stage of the 5-stage pipeline.
- Executes DIV/DIVU using radix-2 restoring division, one quotient bit per cycle.
- Drives stallreq_for_ex into the pipeline controller while busy.
- Returns {remainder, quotient} for the HI/LO write path in MEM/WB.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH.

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start_i  input  1  EX requests a divide (held high until ready_o is seen)
signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
annul_i  input  1  abort in-flight divide (flush); returns to FREE
result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
ready_o  output  1  result_o valid this cycle
stallreq_o  output  1  stall request to controller (`Stop when busy)

Behaviour:
- Reset: rst=1 on clk edge -> state FREE, cnt=0, internal regs 0. result_o=0, ready_o=0, stallreq_o=0. Reset mid-operation abandons the divide with no result.
- States (localparams in shared defines): FREE, BYZERO, ON, END.
- FREE, start_i=1, annul_i=0:
  - opdata2_i==0 -> BYZERO.
  - Otherwise -> ON with cnt=0.
  - Operands latched; when signed_div_i=1, absolute values are taken and the signs of both operands are recorded.
- FREE, other inputs: stay in FREE.
- BYZERO: next cycle -> END with quotient=0 and remainder=0. No exception is raised.
- ON:
  - Each cycle: partial = {rem, dividend MSB}; if partial >= divisor, subtract and set quotient bit = 1, else quotient bit = 0; shift; cnt++.
  - After the 32nd iteration (cnt==WIDTH) -> END.
  - Signed correction is applied on entry to END: quotient negated if the operand signs differ; remainder negated if the dividend was negative.
- ON with annul_i=1: -> FREE immediately. Intermediate state is discarded and ready_o is never raised.
- END:
  - ready_o=1 and result_o valid.
  - Stays in END while start_i=1; start_i=0 -> FREE and ready_o=0 the following cycle.
  - annul_i=1 in END -> FREE.
- stallreq_o (combinational): 1 when (state==FREE & start_i & ~annul_i), or state==ON, or state==BYZERO. 0 in END, so the controller releases the pipeline in the same cycle the result is valid.
- Latency: start sampled at edge T; ON covers T+1..T+32; END (ready_o=1) at T+33. For divisor zero, ready_o=1 at T+2.
- result_o holds its last value outside END. Consumers qualify it with ready_o.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wrap-around, no trap).
- Back-to-back divides: a new start_i is accepted only from FREE; at least one FREE cycle separates two results.
- start_i changing mid-ON is ignored; only annul_i aborts.

Decomposition:
- defines.vh gains DivFree/DivByZero/DivOn/DivEnd (2-bit), DivResultReady/DivResultNotReady, DivStart/DivStop.
- Existing `Stop/`NoStop are reused for stallreq_o.
- No sub-module; the datapath (compare/subtract/shift) stays inline.
- The EX-stage glue that raises start_i and muxes result_o into the HI/LO write is outside this block.

Test Plan:
- DIVU 100/7 (start held) -> stallreq_o=1 for cycles T..T+32, ready_o=1 at T+33, result_o={32'd2, 32'd14}; after start_i=0, state FREE and ready_o=0 next cycle.
- DIV -100/7 (0xFFFFFF9C, 7) -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); DIV 100/-7 -> quotient -14, remainder 2.
- Divisor 0 (either signedness) -> ready_o at T+2, result_o=0, stallreq_o=1 only for cycles T and T+1.
- Overflow DIV 0x80000000/0xFFFFFFFF -> result_o={32'h0, 32'h80000000}; DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- annul_i pulsed at T+10 mid-ON -> FREE at T+11, stallreq_o=0 with start_i low, ready_o never asserted; a new DIVU 9/3 then completes with {0, 3}.
- rst asserted at T+5 mid-ON -> all outputs 0 next edge; a following DIVU 0xFFFFFFFF/0x10000 -> {0xFFFF, 0xFFFF} at the normal 33-cycle latency.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider: FSM state encoding
// and the named levels used on its ready/start/stall signals.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic STOP                 = 1'b1;
    localparam logic NO_STOP              = 1'b0;

endpackage

// File: rtl/div_if.sv
// EX-stage <-> divider request/result bundle. The master side is the EX glue;
// the slave side is div_unit.
interface div_if #(parameter int WIDTH = 32);

    logic                 start_i;
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stallreq_o;

    modport master (
        output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, stallreq_o
    );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle. Signed divides run on
// magnitudes and the signs are reapplied as the result is captured.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic clk,
    input  logic rst,
    div_if.slave div
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t           state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]     dividend_reg, dividend_next;
    logic [WIDTH-1:0]     divisor_reg, divisor_next;
    logic [WIDTH-1:0]     rem_reg, rem_next;
    logic                 neg_quot_reg, neg_quot_next;
    logic                 neg_rem_reg, neg_rem_next;
    logic [2*WIDTH-1:0]   result_reg, result_next;
    logic                 stall;

    logic [WIDTH-1:0]     abs_op1, abs_op2;
    logic [WIDTH:0]       partial, diff;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_iter, quot_iter, rem_fix, quot_fix;

    // The most negative value maps onto itself, which as an unsigned magnitude
    // is exactly right, so overflow wraps instead of needing special handling.
    assign abs_op1 = (div.signed_div_i && div.opdata1_i[WIDTH-1]) ? -div.opdata1_i : div.opdata1_i;
    assign abs_op2 = (div.signed_div_i && div.opdata2_i[WIDTH-1]) ? -div.opdata2_i : div.opdata2_i;

    // Quotient bits are shifted into the vacated low end of the dividend.
    assign partial   = {rem_reg, dividend_reg[WIDTH-1]};
    assign diff      = partial - {1'b0, divisor_reg};
    assign q_bit     = ~diff[WIDTH];
    assign rem_iter  = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    assign quot_iter = {dividend_reg[WIDTH-2:0], q_bit};
    assign rem_fix   = neg_rem_reg  ? -rem_iter  : rem_iter;
    assign quot_fix  = neg_quot_reg ? -quot_iter : quot_iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= DIV_FREE;
            cnt_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            neg_quot_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            result_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            rem_reg      <= rem_next;
            neg_quot_reg <= neg_quot_next;
            neg_rem_reg  <= neg_rem_next;
            result_reg   <= result_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        rem_next      = rem_reg;
        neg_quot_next = neg_quot_reg;
        neg_rem_next  = neg_rem_reg;
        result_next   = result_reg;
        stall         = NO_STOP;

        unique case (state_reg)
            DIV_FREE: begin
                if (div.start_i == DIV_START && !div.annul_i) begin
                    stall         = STOP;
                    cnt_next      = '0;
                    rem_next      = '0;
                    dividend_next = abs_op1;
                    divisor_next  = abs_op2;
                    neg_quot_next = div.signed_div_i & (div.opdata1_i[WIDTH-1] ^ div.opdata2_i[WIDTH-1]);
                    neg_rem_next  = div.signed_div_i & div.opdata1_i[WIDTH-1];
                    state_next    = (div.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: begin
                stall       = STOP;
                result_next = '0;
                state_next  = DIV_END;
            end
            DIV_ON: begin
                stall = STOP;
                if (div.annul_i) begin
                    state_next = DIV_FREE;
                end else begin
                    dividend_next = quot_iter;
                    rem_next      = rem_iter;
                    cnt_next      = cnt_reg + 1'b1;
                    // Last iteration: capture the sign-corrected result directly.
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        result_next = {rem_fix, quot_fix};
                        state_next  = DIV_END;
                    end
                end
            end
            DIV_END: begin
                if (div.annul_i || div.start_i == DIV_STOP) begin
                    state_next = DIV_FREE;
                end
            end
            default: state_next = DIV_FREE;
        endcase
    end

    assign div.result_o   = result_reg;
    assign div.ready_o    = (state_reg == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    assign div.stallreq_o = stall;

endmodule

// File: tb/tb_div_unit.sv
// Directed check of div_unit: a vector table of divides plus annul and
// mid-operation reset sequences.
module tb_div_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .div (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one divide with start held through one extra END cycle, then drops it.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int lat, input string name);
        int   n;
        logic stall_ok;
        bus.start_i      = 1'b1;
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        #1;
        stall_ok = (bus.stallreq_o === 1'b1);
        n = 0;
        do begin
            step();
            n++;
            if (bus.ready_o !== 1'b1 && bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
        end while (bus.ready_o !== 1'b1 && n < 40);
        check({name, " latency"}, 64'(n), 64'(lat));
        if (bus.stallreq_o !== 1'b0) stall_ok = 1'b0;
        check({name, " stall"}, {63'd0, stall_ok}, 64'd1);
        check({name, " result"}, bus.result_o, exp);
        step();
        check({name, " end_hold"}, {62'd0, bus.ready_o, bus.stallreq_o}, 64'd2);
        bus.start_i = 1'b0;
        step();
        check({name, " release"}, {62'd0, bus.ready_o, bus.stallreq_o}, 64'd0);
        check({name, " result_hold"}, bus.result_o, exp);
        $display("div %s sg=%0d a=%h b=%h -> result=%h lat=%0d", name, sg, a, b, bus.result_o, n);
    endtask

    initial begin
        int   seen_ready;
        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         33, "divu_100_7"};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE,   32'hFFFFFFF2},   33, "div_m100_7"};
        vecs[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   {32'd2,          32'hFFFFFFF2},   33, "div_100_m7"};
        vecs[3]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE,   32'd14},         33, "div_m100_m7"};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          64'd0,                            2,  "divu_by0"};
        vecs[5]  = '{1'b1, 32'hFFFFFF9C,   32'd0,          64'd0,                            2,  "div_by0"};
        vecs[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,          32'h80000000},   33, "div_ovf"};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0,          32'hFFFFFFFF},   33, "divu_max_1"};
        vecs[8]  = '{1'b0, 32'd3,          32'd10,         {32'd3,          32'd0},          33, "divu_3_10"};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'h00010000,   {32'h0000FFFF,   32'h0000FFFF},   33, "divu_max_64k"};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0,          32'd1},          33, "divu_max_max"};

        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.annul_i      = 1'b0;
        step();
        step();
        check("reset outputs", {bus.result_o[61:0], bus.ready_o, bus.stallreq_o}, 64'd0);
        check("reset result", bus.result_o, 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);
        end

        // Annul in the middle of ON: cycle T+10 carries the pulse.
        bus.start_i      = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        step();
        bus.start_i = 1'b0;
        for (int i = 0; i < 9; i++) step();
        bus.annul_i = 1'b1;
        #1;
        check("annul stall_in_on", {63'd0, bus.stallreq_o}, 64'd1);
        step();
        bus.annul_i = 1'b0;
        #1;
        check("annul free", {62'd0, bus.ready_o, bus.stallreq_o}, 64'd0);
        seen_ready = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.ready_o !== 1'b0 || bus.stallreq_o !== 1'b0) seen_ready++;
        end
        check("annul no_ready", 64'(seen_ready), 64'd0);
        $display("annul sequence: ready/stall cycles after annul=%0d", seen_ready);
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "divu_9_3_after_annul");

        // Reset asserted at T+5 while ON.
        bus.start_i      = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        step();
        for (int i = 0; i < 4; i++) step();
        check("rst_mid stall_in_on", {63'd0, bus.stallreq_o}, 64'd1);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        step();
        check("rst_mid outputs", {62'd0, bus.ready_o, bus.stallreq_o}, 64'd0);
        check("rst_mid result", bus.result_o, 64'd0);
        $display("reset sequence: result=%h ready=%0d stall=%0d", bus.result_o, bus.ready_o, bus.stallreq_o);
        rst = 1'b0;
        step();
        run_div(1'b0, 32'hFFFFFFFF, 32'h00010000, {32'h0000FFFF, 32'h0000FFFF}, 33, "divu_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
